// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared op encodings and FSM states for the HI/LO multiply/divide unit.
// Imported by hilo_muldiv_unit and its divide-step helper.
package hilo_muldiv_unit_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'b001;
    localparam logic [2:0] MDU_OP_MULTU = 3'b010;
    localparam logic [2:0] MDU_OP_DIV   = 3'b011;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b100;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b101;
    localparam logic [2:0] MDU_OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FINISH
    } mdu_state_e;

    // Ops that occupy the iterative datapath for the full run.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_step.sv
// One combinational restoring-division step (one quotient bit).
// Ports: rem_in/quo_in/divisor in; rem_out/quo_out out.
module mdu_div_step
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // rem_in < divisor, so the shifted remainder fits in WIDTH+1 bits
    // and the sign of diff is exact.
    assign shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = ~diff[WIDTH];
    assign rem_out = fits ? diff : shifted;
    assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// Ports: clk, rst, start, op, a, b, cancel -> busy, done, div_by_zero, hi, lo.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state;
    logic [CNT_W-1:0]   cnt;
    // mul: {partial product, multiplier}; div: low half is dividend/quotient
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     rem;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               dz;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy   = (state != ST_IDLE);
    assign sgn_op = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

    // Shift-add: carry out of the add becomes the new top bit.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, mcand} : '0);
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (rem),
        .quo_in  (acc[WIDTH-1:0]),
        .divisor (mcand),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    assign prod_fix = neg_main ? -acc : acc;
    assign quo_fix  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            rem         <= '0;
            is_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        if (is_long_op(op)) begin
                            state    <= ST_CALC;
                            cnt      <= '0;
                            rem      <= '0;
                            mcand    <= (op == MDU_OP_DIV || op == MDU_OP_DIVU)
                                        ? b_mag : a_mag;
                            acc      <= (op == MDU_OP_DIV || op == MDU_OP_DIVU)
                                        ? {{WIDTH{1'b0}}, a_mag}
                                        : {{WIDTH{1'b0}}, b_mag};
                            is_div   <= (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
                            neg_main <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem  <= sgn_op && a[WIDTH-1];
                            dz       <= ((op == MDU_OP_DIV) || (op == MDU_OP_DIVU))
                                        && (b == '0);
                        end else if (op == MDU_OP_MTHI) begin
                            hi <= a;
                        end else if (op == MDU_OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        if (is_div) begin
                            rem            <= rem_nx;
                            acc[WIDTH-1:0] <= quo_nx;
                        end else begin
                            acc <= mul_nx;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    if (!cancel) begin
                        done        <= 1'b1;
                        div_by_zero <= dz;
                        if (!dz) begin
                            if (is_div) begin
                                lo <= quo_fix;
                                hi <= rem_fix;
                            end else begin
                                {hi, lo} <= prod_fix;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed cases plus random ops
// checked against a plain-arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                check("latency", 64'(cyc - e.acc_cyc), 64'(33));
                check("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    // Reference model: HI/LO semantics by plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, output exp_t e);
        longint      sx, sy, q, r;
        logic [63:0] p;
        e.dz = 1'b0;
        e.acc_cyc = cyc + 1;
        case (o)
            OP_MULT: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                {m_hi, m_lo} = p;
            end
            OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                {m_hi, m_lo} = p;
            end
            OP_DIV: begin
                if (y == 0) e.dz = 1'b1;
                else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            OP_DIVU: begin
                if (y == 0) e.dz = 1'b1;
                else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            OP_MTHI: m_hi = x;
            OP_MTLO: m_lo = x;
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            $display("FAIL wait_idle: busy stuck high");
            $fatal(1, "busy timeout");
        end
    endtask

    task automatic drive_start(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        exp_t e;
        logic long_op;
        wait_idle();
        long_op = (o >= OP_MULT) && (o <= OP_DIVU);
        model(o, x, y, e);
        if (long_op) sb.push_back(e);
        drive_start(o, x, y);
        if (!long_op) begin
            check("single_cycle_busy", 64'(busy), 64'(0));
            check("single_cycle_hi", 64'(hi), 64'(m_hi));
            check("single_cycle_lo", 64'(lo), 64'(m_lo));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        int          w;

        rst = 1'b1;
        idle_cycles(3);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_by_zero), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(OP_DIVU, 32'd100, 32'd7);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        issue(OP_DIVU, 32'd5, 32'd0);
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        issue(OP_MTLO, 32'h1234, 32'h0);
        wait_idle();

        // Cancel in flight: no done, HI/LO untouched.
        drive_start(OP_MULT, 32'd6, 32'd7);
        idle_cycles(9);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'(0));
        idle_cycles(40);
        check("cancel_hi", 64'(hi), 64'(m_hi));
        check("cancel_lo", 64'(lo), 64'(m_lo));

        // Start while busy is dropped.
        issue(OP_MULT, 32'd6, 32'd7);
        idle_cycles(5);
        drive_start(OP_MULTU, 32'd9, 32'd9);
        wait_idle();
        idle_cycles(2);
        check("ignored_start_busy", 64'(busy), 64'(0));

        // Start and cancel together: nothing accepted.
        start = 1'b1;
        cancel = 1'b1;
        op = OP_DIVU;
        a = 32'd50;
        b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        check("start_cancel_busy", 64'(busy), 64'(0));
        idle_cycles(40);
        check("start_cancel_lo", 64'(lo), 64'(m_lo));

        // Unused op code.
        drive_start(3'b111, 32'hAAAA_AAAA, 32'h1);
        check("noop_busy", 64'(busy), 64'(0));
        check("noop_hi", 64'(hi), 64'(m_hi));

        // Reset mid-divide clears HI/LO.
        drive_start(OP_DIVU, 32'd1000, 32'd3);
        idle_cycles(19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        idle_cycles(40);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            else if ($urandom_range(0, 1) == 1) ry = $urandom;
            else ry = 32'($urandom_range(1, 50));
            if (ro == 3'b000 || ro == 3'b111) begin
                wait_idle();
                drive_start(ro, rx, ry);
                check("rand_noop_busy", 64'(busy), 64'(0));
            end else begin
                issue(ro, rx, ry);
            end
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
